// File: rtl/switch_allocator.sv
// Switch allocator for a 5-port router: one round-robin arbiter per output
// column, atomic multicast grants, registered grant/crossbar control, and
// optional per-output downstream credit tracking.
// Optional feature macro: SWITCH_ALLOCATOR_CREDIT_EN (credit counters,
// credit gating of outputs, sticky credit_err). Without it every output is
// always eligible and credit_in is ignored.
// Port indices follow the router.vh direction definitions; fallbacks below
// keep this file self-contained when router.vh is not pulled in first.

`ifndef DIRECTION
  `define DIRECTION 5
`endif
`ifndef DIR_LOCAL
  `define DIR_LOCAL 0
`endif
`ifndef DIR_NW
  `define DIR_NW 1
`endif
`ifndef DIR_NE
  `define DIR_NE 2
`endif
`ifndef DIR_SE
  `define DIR_SE 3
`endif
`ifndef DIR_SW
  `define DIR_SW 4
`endif

module switch_allocator #(
  parameter int CREDIT_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [`DIRECTION*`DIRECTION-1:0]    sa_req,
  input  logic [`DIRECTION-1:0]               credit_in,
  output logic [`DIRECTION-1:0]               sa_grant,
  output logic [`DIRECTION*`DIRECTION-1:0]    st_ctrl_out,
  output logic                                credit_err
);

  localparam int N  = `DIRECTION;
  localparam int PW = $clog2(N);

  logic [N-1:0]  req_m [N];    // filtered request rows, req_m[input][output]
  logic [PW-1:0] ptr [N];      // round-robin pointer per output column
  logic [N-1:0]  out_ok;       // output may be arbitrated this cycle
  logic [N-1:0]  win_valid;
  logic [PW-1:0] win [N];      // arbiter winner per output column
  logic [N-1:0]  grant_next;
  logic [N-1:0]  out_used;     // output carries a grant registered this edge

  // Candidate index (base + k) mod N without a divider.
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int k);
    logic [PW:0] s;
    s = {1'b0, base} + (PW+1)'(k);
    return (s >= (PW+1)'(N)) ? PW'(s - (PW+1)'(N)) : PW'(s);
  endfunction

  // Split request rows and drop the illegal LOCAL->LOCAL bit.
  always_comb begin
    for (int i = 0; i < N; i++) req_m[i] = sa_req[i*N +: N];
    req_m[`DIR_LOCAL][`DIR_LOCAL] = 1'b0;
  end

  // Per-output round-robin search from the pointer; inputs granted this cycle sit out.
  // NOTE: every combinational output gets a default before any conditional assignment, so no latch is inferred.
  always_comb begin
    win_valid = '0;
    for (int o = 0; o < N; o++) begin
      win[o] = '0;
      for (int k = 0; k < N; k++) begin
        if (!win_valid[o] && out_ok[o] &&
            req_m[rr_index(ptr[o], k)][o] && !sa_grant[rr_index(ptr[o], k)]) begin
          win_valid[o] = 1'b1;
          win[o]       = rr_index(ptr[o], k);
        end
      end
    end
  end

  // An input is granted only when it wins every output in its mask.
  always_comb begin
    out_used = '0;
    for (int i = 0; i < N; i++) begin
      grant_next[i] = (req_m[i] != '0) && !sa_grant[i];
      for (int o = 0; o < N; o++) begin
        if (req_m[i][o] && !(win_valid[o] && win[o] == PW'(i))) grant_next[i] = 1'b0;
      end
    end
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        if (grant_next[i] && req_m[i][o]) out_used[o] = 1'b1;
      end
    end
  end

  // Register grants and crossbar control; reset clears them without a clock.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_grant    <= '0;
      st_ctrl_out <= '0;
    end else begin
      sa_grant <= grant_next;
      for (int i = 0; i < N; i++) begin
        st_ctrl_out[i*N +: N] <= grant_next[i] ? req_m[i] : '0;
      end
    end
  end

  // Move a column's pointer past its winner only when that winner was granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < N; o++) ptr[o] <= PW'(`DIR_LOCAL);
    end else begin
      for (int o = 0; o < N; o++) begin
        if (win_valid[o] && grant_next[win[o]]) begin
          ptr[o] <= (win[o] == PW'(N-1)) ? '0 : win[o] + 1'b1;
        end
      end
    end
  end

`ifdef SWITCH_ALLOCATOR_CREDIT_EN
  localparam int CW = $clog2(CREDIT_DEPTH+1);

  logic [CW-1:0] credit_cnt [N];

  // Outputs with no downstream slot are not arbitrated.
  always_comb begin
    for (int o = 0; o < N; o++) out_ok[o] = (credit_cnt[o] != '0);
  end

  // Credit counters: consume on grant, refill on credit_in, saturate and flag overflow.
  // NOTE: the counter array is reset explicitly because its start value is architectural.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < N; o++) credit_cnt[o] <= CW'(CREDIT_DEPTH);
      credit_err <= 1'b0;
    end else begin
      for (int o = 0; o < N; o++) begin
        case ({out_used[o], credit_in[o]})
          2'b10:   credit_cnt[o] <= credit_cnt[o] - 1'b1;
          2'b01: begin
            if (credit_cnt[o] == CW'(CREDIT_DEPTH)) credit_err <= 1'b1;
            else                                     credit_cnt[o] <= credit_cnt[o] + 1'b1;
          end
          default: credit_cnt[o] <= credit_cnt[o];
        endcase
      end
    end
  end
`else
  localparam int unused_credit_depth = CREDIT_DEPTH;
  logic unused_credit_in;

  assign out_ok           = '1;
  assign credit_err       = 1'b0;
  assign unused_credit_in = ^{credit_in, out_used};
`endif

endmodule
